uart_io_mc: RTL
===============

UART_IO_MC -- requirements
Module: uart_io_mc

Interface
REQ-001 SHALL have parameter N_CH, default 2, meaning the number of request channels (1..4); the channel index is carried in the 2-bit ThreadID field.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the per-channel request FIFO depth (power of 2, at least 2).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, meaning the response timeout in cycles (used only with the Configuration feature).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have ports ch_req_valid / ch_req_ready, input / output, N_CH bits: per-channel request handshake.
REQ-007 SHALL have port ch_req_write, input, N_CH bits: 1 = write, 0 = read.
REQ-008 SHALL have ports ch_req_addr / ch_req_data, input, N_CH x 32 bits: request address and write data.
REQ-009 SHALL have ports ch_rsp_valid / ch_rsp_error, output, N_CH bits: one-cycle completion pulse and error flag.
REQ-010 SHALL have port ch_rsp_data, output, N_CH x 32 bits: read data (0 for writes and errors).
REQ-011 SHALL have ports C2F_ReqValidQ500H (1), C2F_ReqOpcodeQ500H (t_opcode), C2F_ReqAddressQ500H (32), C2F_ReqDataQ500H (32) and C2F_ReqThreadIDQ500H (2), all outputs, forming the fabric request.
REQ-012 SHALL have ports C2F_RspValidQ502H (1), C2F_RspOpcodeQ502H (t_opcode), C2F_RspDataQ502H (32), C2F_RspStall (1) and C2F_RspThreadIDQ502H (2), all inputs, forming the fabric response.
REQ-013 SHALL have port spurious_err, output, 1 bit: sticky unexpected-response flag.

Function
REQ-014 SHALL buffer each channel in a FIFO of {write, addr, data}, with ch_req_ready[i] = !full[i] & !rst and a push on valid & ready.
REQ-015 SHALL, on a simultaneous push and pop, keep the FIFO count unchanged; a full FIFO SHALL NOT accept a push.
REQ-016 SHALL track each channel as IDLE or WAIT_RSP; a channel is eligible when its FIFO is non-empty and it is IDLE.
REQ-017 SHALL arbitrate round-robin starting at (last granted + 1) mod N_CH, issuing at most one request per cycle.
REQ-018 SHALL issue no request while C2F_RspStall = 1.
REQ-019 SHALL register the request outputs: arbitration in cycle N yields C2F_ReqValidQ500H high for exactly cycle N+1, with opcode WR/RD, FIFO head addr/data, and ThreadID = channel index.
REQ-020 SHALL, on grant, pop the FIFO and move the channel to WAIT_RSP; a channel has at most one request outstanding.
REQ-021 SHALL accept a response when C2F_RspValidQ502H = 1, channel[ThreadID] is in WAIT_RSP, and the opcode matches (WR for a write, RD_RSP for a read).
REQ-022 SHALL, on acceptance, return the channel to IDLE and pulse ch_rsp_valid one cycle later with ch_rsp_error = 0 and ch_rsp_data = C2F_RspDataQ502H for reads, 0 for writes.
REQ-023 SHALL drop any other response (idle channel, ThreadID >= N_CH, opcode mismatch) and set spurious_err until reset.
REQ-024 SHALL NOT make a channel released by a response in cycle N eligible before cycle N+1.

Reset
REQ-025 SHALL, while rst = 1, hold all request outputs, ch_rsp_valid, ch_rsp_error, ch_rsp_data and spurious_err at 0 and the opcode at RD.
REQ-026 SHALL, on reset, empty all FIFOs, set all channels to IDLE, set the arbiter pointer to channel 0 and clear timeout counters.
REQ-027 SHALL treat responses to requests issued before a mid-operation reset, arriving after reset, as spurious (REQ-023).

Configuration
REQ-028 SHALL, when UART_IO_MC_TIMEOUT_EN is defined, count cycles in WAIT_RSP per channel and, at TIMEOUT_CYC cycles, return the channel to IDLE and pulse ch_rsp_valid with ch_rsp_error = 1 and data 0; a later response to that request is spurious.
REQ-029 SHALL, when UART_IO_MC_TIMEOUT_EN is undefined, have no counters, tie ch_rsp_error to 0, and wait indefinitely in WAIT_RSP.

Verification
REQ-030 SHALL verify: channel 0 read of 0x0000_1000 with RD_RSP data 0xDEAD_BEEF on ThreadID 0 -> ch_rsp_valid[0] pulses with data 0xDEADBEEF and error 0.
REQ-031 SHALL verify: both channels pushing writes in the same cycle -> grants alternate 0,1,0,1 with ThreadID matching the channel.
REQ-032 SHALL verify: 5 back-to-back pushes into a FIFO_DEPTH=4 channel held in WAIT_RSP -> ch_req_ready falls after the 4th push; the 5th is held.
REQ-033 SHALL verify: C2F_RspStall high for 10 cycles with pending requests -> no C2F_ReqValidQ500H until stall drops, then issue on the next cycle.
REQ-034 SHALL verify: a WR response on ThreadID 1 while channel 1 is IDLE -> no ch_rsp_valid and spurious_err = 1 until rst.
REQ-035 SHALL verify, with TIMEOUT_EN and TIMEOUT_CYC = 16: no response -> at cycle 16 ch_rsp_error[0] = 1; a late response sets spurious_err.

Source files
------------

// File: rtl/uart_io_mc.sv
// Multi-channel request concentrator: per-channel FIFOs, round-robin issue onto the fabric, response routing.
// Optional feature: define UART_IO_MC_TIMEOUT_EN to add per-channel response timeouts.

package uart_io_mc_pkg;
    typedef enum logic [1:0] {
        RD     = 2'd0,
        WR     = 2'd1,
        RD_RSP = 2'd2,
        RSVD   = 2'd3
    } t_opcode;
endpackage

module uart_io_mc
    import uart_io_mc_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      ch_req_valid,
    output logic [N_CH-1:0]      ch_req_ready,
    input  logic [N_CH-1:0]      ch_req_write,
    input  logic [N_CH*32-1:0]   ch_req_addr,
    input  logic [N_CH*32-1:0]   ch_req_data,
    output logic [N_CH-1:0]      ch_rsp_valid,
    output logic [N_CH-1:0]      ch_rsp_error,
    output logic [N_CH*32-1:0]   ch_rsp_data,
    output logic                 C2F_ReqValidQ500H,
    output t_opcode              C2F_ReqOpcodeQ500H,
    output logic [31:0]          C2F_ReqAddressQ500H,
    output logic [31:0]          C2F_ReqDataQ500H,
    output logic [1:0]           C2F_ReqThreadIDQ500H,
    input  logic                 C2F_RspValidQ502H,
    input  t_opcode              C2F_RspOpcodeQ502H,
    input  logic [31:0]          C2F_RspDataQ502H,
    input  logic                 C2F_RspStall,
    input  logic [1:0]           C2F_RspThreadIDQ502H,
    output logic                 spurious_err
);

    localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENTRY_W = 65;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    logic [ENTRY_W-1:0] fifo_mem_q [N_CH][FIFO_DEPTH];
    ptr_t               wr_ptr_q   [N_CH];
    ptr_t               rd_ptr_q   [N_CH];
    cnt_t               count_q    [N_CH];
    logic [ENTRY_W-1:0] head_s     [N_CH];

    logic [N_CH-1:0]    full_s;
    logic [N_CH-1:0]    empty_s;
    logic [N_CH-1:0]    push_s;
    logic [N_CH-1:0]    pop_s;
    logic [N_CH-1:0]    eligible_s;
    logic [N_CH-1:0]    busy_q;
    logic [N_CH-1:0]    pend_wr_q;
    logic [N_CH-1:0]    rsp_hit_s;
    logic [N_CH-1:0]    timeout_s;
    logic               rsp_spurious_s;

    logic [1:0]         rr_ptr_q;
    logic               grant_s;
    logic [1:0]         grant_idx_s;
    logic [ENTRY_W-1:0] grant_head_s;
    int                 arb_idx_s;
    logic               arb_hit_s;

    // FIFO status and channel eligibility; a busy flag cleared at an edge only matters from the next cycle
    always_comb begin
        full_s  = '0;
        empty_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            full_s[i]  = (count_q[i] == cnt_t'(FIFO_DEPTH));
            empty_s[i] = (count_q[i] == cnt_t'(0));
            head_s[i]  = fifo_mem_q[i][rd_ptr_q[i]];
        end
        eligible_s = ~empty_s & ~busy_q & {N_CH{~C2F_RspStall}};
    end

    assign ch_req_ready = ~full_s & {N_CH{~rst}};
    assign push_s       = ch_req_valid & ch_req_ready;

    // Round-robin pick starting at the pointer, first eligible channel wins
    always_comb begin
        grant_s      = 1'b0;
        grant_idx_s  = 2'd0;
        arb_idx_s    = 0;
        arb_hit_s    = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            arb_idx_s   = (int'(rr_ptr_q) + k) % N_CH;
            arb_hit_s   = !grant_s && eligible_s[arb_idx_s];
            grant_idx_s = arb_hit_s ? 2'(arb_idx_s) : grant_idx_s;
            grant_s     = grant_s | arb_hit_s;
        end
    end

    // Pop decode and head-of-line selection for the granted channel
    always_comb begin
        pop_s        = '0;
        grant_head_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            pop_s[i]     = grant_s && (grant_idx_s == 2'(i));
            grant_head_s = grant_head_s | (pop_s[i] ? head_s[i] : {ENTRY_W{1'b0}});
        end
    end

    // Response routing: accept only a matching opcode on a channel that is waiting
    always_comb begin
        rsp_hit_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            rsp_hit_s[i] = C2F_RspValidQ502H
                        && (C2F_RspThreadIDQ502H == 2'(i))
                        && busy_q[i]
                        && (pend_wr_q[i] ? (C2F_RspOpcodeQ502H == WR)
                                         : (C2F_RspOpcodeQ502H == RD_RSP));
        end
        rsp_spurious_s = C2F_RspValidQ502H && (rsp_hit_s == '0);
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (push_s[i]) begin
                fifo_mem_q[i][wr_ptr_q[i]] <= {ch_req_write[i], ch_req_addr[i*32 +: 32],
                                               ch_req_data[i*32 +: 32]};
            end
        end
    end

    // FIFO pointers, channel state, arbiter pointer and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            busy_q               <= '0;
            pend_wr_q            <= '0;
            rr_ptr_q             <= 2'd0;
            C2F_ReqValidQ500H    <= 1'b0;
            C2F_ReqOpcodeQ500H   <= RD;
            C2F_ReqAddressQ500H  <= 32'd0;
            C2F_ReqDataQ500H     <= 32'd0;
            C2F_ReqThreadIDQ500H <= 2'd0;
            ch_rsp_valid         <= '0;
            ch_rsp_data          <= '0;
            spurious_err         <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (push_s[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + ptr_t'(1);
                end
                if (pop_s[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + ptr_t'(1);
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   count_q[i] <= count_q[i] + cnt_t'(1);
                    2'b01:   count_q[i] <= count_q[i] - cnt_t'(1);
                    default: count_q[i] <= count_q[i];
                endcase
                if (pop_s[i]) begin
                    busy_q[i]    <= 1'b1;
                    pend_wr_q[i] <= head_s[i][64];
                end else if (rsp_hit_s[i] || timeout_s[i]) begin
                    busy_q[i]    <= 1'b0;
                end
                ch_rsp_valid[i]        <= rsp_hit_s[i] || timeout_s[i];
                ch_rsp_data[i*32 +: 32] <= (rsp_hit_s[i] && !pend_wr_q[i]) ? C2F_RspDataQ502H
                                                                           : 32'd0;
            end

            if (grant_s) begin
                rr_ptr_q             <= 2'((int'(grant_idx_s) + 1) % N_CH);
                C2F_ReqOpcodeQ500H   <= grant_head_s[64] ? WR : RD;
                C2F_ReqAddressQ500H  <= grant_head_s[63:32];
                C2F_ReqDataQ500H     <= grant_head_s[31:0];
                C2F_ReqThreadIDQ500H <= grant_idx_s;
            end
            C2F_ReqValidQ500H <= grant_s;

            if (rsp_spurious_s) begin
                spurious_err <= 1'b1;
            end
        end
    end

`ifdef UART_IO_MC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] to_cnt_q [N_CH];

    // A genuine response in the expiry cycle wins over the timeout
    always_comb begin
        timeout_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            timeout_s[i] = busy_q[i] && !rsp_hit_s[i] && (to_cnt_q[i] == TW'(TIMEOUT_CYC - 1));
        end
    end

    // Per-channel wait counters and the error flag that accompanies a timeout completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                to_cnt_q[i] <= '0;
            end
            ch_rsp_error <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                to_cnt_q[i] <= (busy_q[i] && !rsp_hit_s[i] && !timeout_s[i])
                             ? to_cnt_q[i] + TW'(1) : '0;
            end
            ch_rsp_error <= timeout_s;
        end
    end
`else
    assign timeout_s    = '0;
    assign ch_rsp_error = '0;
`endif

endmodule
